// File: rtl/mouse_axis_emu.sv
// Mouse-to-analog-axis emulator: PS/2 packets accumulate into saturating
// signed X/Y positions that stand in for player 1's analog stick.
//
// Ports:
//   i_clk_sys      single clock; synchronous active-low reset i_reset_n
//   i_ps2_mouse    hps_io mouse word ([24] toggle strobe, [23:16] Y,
//                  [15:8] X, [5] Y sign, [4] X sign, [1:0] buttons)
//   i_invert       bit0 negates X steps, bit1 negates Y steps
//   i_sens_shift   arithmetic right shift (0..3) of raw deltas
//   i_recenter_en  enables decay of the axes toward zero
//   i_release      level; while high the block is forced inactive
//   o_axis_x/y     signed axis positions (AXIS_W bits)
//   o_emu_active   axes are currently driven by the mouse
//   o_mbuttons     latched mouse buttons, 0 while inactive
module mouse_axis_emu #(
  parameter int AXIS_W    = 8,
  parameter int DELTA_MAX = 10,
  parameter int DECAY_DIV = 65536
) (
  input  logic              i_clk_sys,
  input  logic              i_reset_n,
  input  logic [24:0]       i_ps2_mouse,
  input  logic [1:0]        i_invert,
  input  logic [1:0]        i_sens_shift,
  input  logic              i_recenter_en,
  input  logic              i_release,
  output logic [AXIS_W-1:0] o_axis_x,
  output logic [AXIS_W-1:0] o_axis_y,
  output logic              o_emu_active,
  output logic [1:0]        o_mbuttons
);

  localparam int SW = AXIS_W + 2;
  localparam int CW = $clog2(DECAY_DIV);
  localparam logic [CW-1:0] LOAD = CW'(DECAY_DIV - 1);
  localparam logic signed [SW-1:0] MAXV =
    SW'((1 << (AXIS_W - 1)) - 1);
  localparam logic signed [SW-1:0] MINV = -MAXV - 1;
  localparam logic signed [15:0] DMAX = 16'(DELTA_MAX);

  typedef enum logic {
    S_INACTIVE = 1'b0,
    S_ACTIVE   = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic              r_prev_stb;
  logic              r_pkt_v;
  logic [AXIS_W-1:0] r_dx;
  logic [AXIS_W-1:0] r_dy;
  logic [1:0]        r_btn;
  logic [AXIS_W-1:0] r_axis_x;
  logic [AXIS_W-1:0] r_axis_y;
  logic [1:0]        r_mbtn;
  logic [CW-1:0]     r_cnt;

  logic              w_pkt;
  logic              w_accept;
  logic              w_tick;
  logic              w_reload;
  logic [AXIS_W-1:0] w_dx;
  logic [AXIS_W-1:0] w_dy;
  logic              w_unused;

  // Shift, clamp to +-DELTA_MAX, then optionally negate.
  function automatic logic [AXIS_W-1:0] f_step(
    input logic       s,
    input logic [7:0] d,
    input logic       inv,
    input logic [1:0] sh
  );
    logic signed [15:0] v;
    v = {{7{s}}, s, d};
    v = v >>> sh;
    if (v > DMAX)
      v = DMAX;
    else if (v < -DMAX)
      v = -DMAX;
    if (inv)
      v = -v;
    return v[AXIS_W-1:0];
  endfunction

  // Two guard bits keep the sum exact before saturation.
  function automatic logic [AXIS_W-1:0] f_sat_add(
    input logic [AXIS_W-1:0] a,
    input logic [AXIS_W-1:0] b
  );
    logic signed [SW-1:0] s;
    s = {{2{a[AXIS_W-1]}}, a} + {{2{b[AXIS_W-1]}}, b};
    if (s > MAXV)
      s = MAXV;
    else if (s < MINV)
      s = MINV;
    return s[AXIS_W-1:0];
  endfunction

  function automatic logic [AXIS_W-1:0] f_decay(
    input logic [AXIS_W-1:0] a
  );
    logic [AXIS_W-1:0] r;
    r = a;
    if (a != '0) begin
      if (a[AXIS_W-1])
        r = a + 1'b1;
      else
        r = a - 1'b1;
    end
    return r;
  endfunction

  assign w_pkt    = i_ps2_mouse[24] ^ r_prev_stb;
  assign w_accept = w_pkt & ~i_release;
  assign w_tick   = (r_state == S_ACTIVE) & i_recenter_en
                  & (r_cnt == '0);
  assign w_reload = i_release | r_pkt_v | ~i_recenter_en
                  | (r_state != S_ACTIVE) | w_tick;

  assign w_dx = f_step(i_ps2_mouse[4], i_ps2_mouse[15:8],
                       i_invert[0], i_sens_shift);
  assign w_dy = f_step(i_ps2_mouse[5], i_ps2_mouse[23:16],
                       i_invert[1], i_sens_shift);

  assign w_unused = ^{i_ps2_mouse[7:6], i_ps2_mouse[3:2]};

  always_comb begin
    w_state_nxt = r_state;
    if (i_release)
      w_state_nxt = S_INACTIVE;
    else if (r_pkt_v)
      w_state_nxt = S_ACTIVE;
  end

  always_ff @(posedge i_clk_sys) begin
    if (!i_reset_n)
      r_state <= S_INACTIVE;
    else
      r_state <= w_state_nxt;
  end

  always_ff @(posedge i_clk_sys) begin
    if (!i_reset_n) begin
      // Ignore a strobe that already toggled before reset ended.
      r_prev_stb <= i_ps2_mouse[24];
      r_pkt_v    <= 1'b0;
      r_dx       <= '0;
      r_dy       <= '0;
      r_btn      <= '0;
      r_axis_x   <= '0;
      r_axis_y   <= '0;
      r_mbtn     <= '0;
      r_cnt      <= LOAD;
    end else begin
      r_prev_stb <= i_ps2_mouse[24];
      r_pkt_v    <= w_accept;
      if (w_accept) begin
        r_dx  <= w_dx;
        r_dy  <= w_dy;
        r_btn <= i_ps2_mouse[1:0];
      end
      if (i_release) begin
        r_axis_x <= '0;
        r_axis_y <= '0;
        r_mbtn   <= '0;
      end else if (r_pkt_v) begin
        r_axis_x <= f_sat_add(r_axis_x, r_dx);
        r_axis_y <= f_sat_add(r_axis_y, r_dy);
        r_mbtn   <= r_btn;
      end else if (w_tick) begin
        r_axis_x <= f_decay(r_axis_x);
        r_axis_y <= f_decay(r_axis_y);
      end
      if (w_reload)
        r_cnt <= LOAD;
      else
        r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_axis_x     = r_axis_x;
  assign o_axis_y     = r_axis_y;
  assign o_emu_active = (r_state == S_ACTIVE);
  assign o_mbuttons   = r_mbtn;

endmodule
